// File: rtl/execute_stage.sv
// Execute stage: ALU, condition codes and branch/cmov condition, one result register toward memory.
// Latency 1 cycle; in_ready drops while the result is held unconsumed, during reset, or after a halt.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_icode,
  output logic [63:0] out_valE,
  output logic [63:0] out_valA,
  output logic        out_Cnd,
  output logic        out_err,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic        cnd;
    logic        err;
  } ex_res_t;

  ex_res_t     res_d, res_q;
  logic [63:0] alu_a, alu_b, val_e;
  logic        of_d, err_d, cnd_d;
  logic        halted, accept, cc_wr, lt;

  assign in_ready = rst_n & ~halted & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    alu_a = 64'd0;
    case (icode)
      I_CMOV, I_OPQ:                alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
      I_CALL, I_PUSHQ:              alu_a = -64'd8;
      I_RET, I_POPQ:                alu_a = 64'd8;
      default:                      alu_a = 64'd0;
    endcase
  end

  always_comb begin
    alu_b = 64'd0;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
      default: alu_b = 64'd0;
    endcase
  end

  always_comb begin
    val_e = alu_b + alu_a;
    of_d  = 1'b0;
    err_d = 1'b0;
    if (icode == I_OPQ) begin
      case (ifun)
        4'd0: begin
          val_e = alu_b + alu_a;
          of_d  = (alu_a[63] == alu_b[63]) & (val_e[63] != alu_a[63]);
        end
        4'd1: begin
          val_e = alu_b - alu_a;
          of_d  = (alu_a[63] != alu_b[63]) & (val_e[63] != alu_b[63]);
        end
        4'd2:    val_e = alu_b & alu_a;
        4'd3:    val_e = alu_b ^ alu_a;
        default: begin
          val_e = 64'd0;
          err_d = 1'b1;
        end
      endcase
    end
  end

  // Condition uses the flags as they stand before this instruction writes them.
  assign lt = cc_sf ^ cc_of;
  always_comb begin
    cnd_d = 1'b0;
    if (icode == I_CMOV || icode == I_JXX) begin
      case (ifun)
        4'd0:    cnd_d = 1'b1;
        4'd1:    cnd_d = lt | cc_zf;
        4'd2:    cnd_d = lt;
        4'd3:    cnd_d = cc_zf;
        4'd4:    cnd_d = ~cc_zf;
        4'd5:    cnd_d = ~lt;
        4'd6:    cnd_d = ~lt & ~cc_zf;
        default: cnd_d = 1'b0;
      endcase
    end
  end

  assign res_d = '{icode: icode, val_e: val_e, val_a: valA, cnd: cnd_d, err: err_d};
  assign cc_wr = accept & (icode == I_OPQ) & ~err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
      cc_zf     <= 1'b1;
      cc_sf     <= 1'b0;
      cc_of     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (accept) begin
        res_q     <= res_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cc_wr) begin
        cc_zf <= (val_e == 64'd0);
        cc_sf <= val_e[63];
        cc_of <= of_d;
      end
      if (accept && icode == I_HALT) halted <= 1'b1;
    end
  end

  assign out_icode = res_q.icode;
  assign out_valE  = res_q.val_e;
  assign out_valA  = res_q.val_a;
  assign out_Cnd   = res_q.cnd;
  assign out_err   = res_q.err;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboarded bench for execute_stage: reference model pushes expected results on accept, monitor pops on delivery.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic        out_valid, out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_valE, out_valA;
  logic        out_Cnd, out_err;
  logic        cc_zf, cc_sf, cc_of;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] vale;
    logic [63:0] vala;
    logic        cnd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   failures = 0;
  logic m_zf, m_sf, m_of;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .out_valA(out_valA), .out_Cnd(out_Cnd), .out_err(out_err),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  // Reference model: computes the result of an accepted instruction and advances the model flags.
  task automatic model_accept(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [63:0] aa, bb, e;
    logic cnd, err, of;
    exp_t x;
    case (ic)
      4'h2, 4'h6:       aa = a;
      4'h3, 4'h4, 4'h5: aa = c;
      4'h8, 4'hA:       aa = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       aa = 64'd8;
      default:          aa = 64'd0;
    endcase
    bb  = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? b : 64'd0;
    err = 1'b0;
    of  = 1'b0;
    e   = bb + aa;
    if (ic == 4'h6) begin
      if (fn == 4'd0) begin e = bb + aa; of = (aa[63] == bb[63]) && (e[63] != aa[63]); end
      else if (fn == 4'd1) begin e = bb - aa; of = (aa[63] != bb[63]) && (e[63] != bb[63]); end
      else if (fn == 4'd2) e = bb & aa;
      else if (fn == 4'd3) e = bb ^ aa;
      else begin e = 64'd0; err = 1'b1; end
    end
    cnd = 1'b0;
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'd0: cnd = 1'b1;
        4'd1: cnd = (m_sf != m_of) || m_zf;
        4'd2: cnd = (m_sf != m_of);
        4'd3: cnd = m_zf;
        4'd4: cnd = !m_zf;
        4'd5: cnd = (m_sf == m_of);
        4'd6: cnd = (m_sf == m_of) && !m_zf;
        default: cnd = 1'b0;
      endcase
    end
    x.icode = ic; x.vale = e; x.vala = a; x.cnd = cnd; x.err = err;
    sb.push_back(x);
    if (ic == 4'h6 && !err) begin
      m_zf = (e == 64'd0);
      m_sf = e[63];
      m_of = of;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: out_icode=%h out_valE=%h with nothing expected", out_icode, out_valE);
      end else begin
        mon_x = sb.pop_front();
        if ({out_icode, out_valE, out_valA, out_Cnd, out_err} !== mon_x) begin
          failures++;
          $display("FAIL sb_result: got icode=%h valE=%h valA=%h Cnd=%b err=%b want icode=%h valE=%h valA=%h Cnd=%b err=%b",
                   out_icode, out_valE, out_valA, out_Cnd, out_err,
                   mon_x.icode, mon_x.vale, mon_x.vala, mon_x.cnd, mon_x.err);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input bit rnd);
    bit done = 0;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; in_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        model_accept(ic, fn, a, b, c);
        done = 1;
      end
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: icode=%h never accepted, in_ready=%b required 1", ic, in_ready);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL post_rst: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({out_valid, out_icode, out_valE, out_valA, out_Cnd, out_err} !== '0 ||
        {cc_zf, cc_sf, cc_of} !== 3'b100 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b icode=%h valE=%h valA=%h Cnd=%b err=%b cc=%b%b%b in_ready=%b want all 0, cc=100",
               out_valid, out_icode, out_valE, out_valA, out_Cnd, out_err, cc_zf, cc_sf, cc_of, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_pre_valid: got %b want 0", out_valid); end
    send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_valE !== 64'h8000_0000_0000_0000 || {cc_zf, cc_sf, cc_of} !== 3'b011) begin
      failures++;
      $display("FAIL add_overflow: valid=%b valE=%h cc=%b%b%b want 1 8000000000000000 011",
               out_valid, out_valE, cc_zf, cc_sf, cc_of);
    end
  endtask

  task automatic test_sub_jump();
    send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 0);
    checks++;
    if (out_valE !== 64'd0 || cc_zf !== 1'b1) begin
      failures++; $display("FAIL sub_zero: valE=%h zf=%b want 0 1", out_valE, cc_zf);
    end
    send(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 0);
    checks++;
    if (out_Cnd !== 1'b1) begin failures++; $display("FAIL je_taken: Cnd=%b want 1", out_Cnd); end
    send(4'h7, 4'h4, 64'd0, 64'd0, 64'h80, 0);
    checks++;
    if (out_Cnd !== 1'b0) begin failures++; $display("FAIL jne_not_taken: Cnd=%b want 0", out_Cnd); end
  endtask

  task automatic test_push_pop();
    send(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 0);
    checks++;
    if (out_valE !== 64'hF8) begin failures++; $display("FAIL pushq_valE: got %h want f8", out_valE); end
    send(4'hB, 4'h0, 64'h55, 64'h100, 64'd0, 0);
    checks++;
    if (out_valE !== 64'h108 || {cc_zf, cc_sf, cc_of} !== 3'b100) begin
      failures++; $display("FAIL popq: valE=%h cc=%b%b%b want 108 100", out_valE, cc_zf, cc_sf, cc_of);
    end
  endtask

  task automatic test_stall();
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 0);
    icode = 4'h6; ifun = 4'h1; valA = 64'd3; valB = 64'd3; valC = 64'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_icode !== 4'h6 || out_valE !== 64'd3 ||
          out_valA !== 64'd1 || {cc_zf, cc_sf, cc_of} !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b icode=%h valE=%h valA=%h cc=%b%b%b want 0 1 6 3 1 000",
                 i, in_ready, out_valid, out_icode, out_valE, out_valA, cc_zf, cc_sf, cc_of);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release: in_ready=%b want 1", in_ready);
    end else model_accept(4'h6, 4'h1, 64'd3, 64'd3, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_valE !== 64'd0 || cc_zf !== 1'b1) begin
      failures++; $display("FAIL stall_next: valid=%b valE=%h zf=%b want 1 0 1", out_valid, out_valE, cc_zf);
    end
  endtask

  task automatic test_err();
    send(4'h6, 4'h7, 64'h1234, 64'h5678, 64'd0, 0);
    checks++;
    if (out_err !== 1'b1 || out_valE !== 64'd0 || {cc_zf, cc_sf, cc_of} !== 3'b100) begin
      failures++; $display("FAIL opq_err: err=%b valE=%h cc=%b%b%b want 1 0 100", out_err, out_valE, cc_zf, cc_sf, cc_of);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ic, fn;
    logic [63:0] a, b, c;
    for (int i = 0; i < 60; i++) begin
      ic = 4'($urandom_range(1, 11));
      fn = (ic == 4'h2 || ic == 4'h6 || ic == 4'h7) ? 4'($urandom_range(0, 8)) : 4'h0;
      a  = {$urandom, $urandom};
      b  = (i % 4 == 0) ? a : {$urandom, $urandom};
      c  = {$urandom, $urandom};
      if (i % 5 == 1) a = 64'h8000_0000_0000_0000;
      out_ready = 1'($urandom_range(0, 1));
      send(ic, fn, a, b, c, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 0);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pending: valid=%b want 1", out_valid); end
    out_ready = 1'b1;
    do_reset();
  endtask

  task automatic test_halt();
    send(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_icode !== 4'h0) begin
      failures++; $display("FAIL halt_delivered: valid=%b icode=%h want 1 0", out_valid, out_icode);
    end
    icode = 4'h1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL halt_sticky[%0d]: in_ready=%b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_jump();
    test_push_pop();
    test_stall();
    test_err();
    test_random();
    test_reset_mid();
    test_halt();
    send(4'h6, 4'h2, 64'hF0, 64'hFF, 64'd0, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: %0d results outstanding, want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL use the following ports:
- clk  input  1  rising-edge clock, single domain
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream (decode) offers an instruction
- in_ready  output  1  block accepts the offered instruction this cycle
- icode  input  4  instruction code: 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq
- ifun  input  4  function code
- valA  input  64  decode operand A
- valB  input  64  decode operand B
- valC  input  64  instruction constant
- out_valid  output  1  registered result present for memory stage
- out_ready  input  1  downstream consumes the result this cycle
- out_icode  output  4  registered icode
- out_valE  output  64  registered ALU result
- out_valA  output  64  registered valA pass-through
- out_Cnd  output  1  registered condition outcome
- out_err  output  1  registered invalid-function flag
- cc_zf, cc_sf, cc_of  output  1 each  condition-code register

Function
REQ-002 aluA SHALL be valA for icode 2 and 6; valC for icode 3, 4 and 5; -8 for icode 8 and A; +8 for icode 9 and B; 0 otherwise.
REQ-003 aluB SHALL be valB for icode 4, 5, 6, 8, 9, A and B, and 0 otherwise.
REQ-004 For icode 6, the ALU function SHALL be selected by ifun: 0 gives B+A, 1 gives B-A, 2 gives B&A, 3 gives B^A; all other icodes SHALL use B+A.
REQ-005 All arithmetic SHALL be 64-bit two's complement, with the carry-out discarded (wrap-around).
REQ-006 icode 6 with ifun>3 SHALL produce valE=0 and err=1, and SHALL leave CC unchanged; err SHALL be 0 in all other cases.
REQ-007 CC SHALL update only on an accepted icode 6 with ifun<=3:
- ZF = (valE==0)
- SF = valE[63]
- OF for add = (A[63]==B[63]) & (valE[63]!=A[63])
- OF for sub = (A[63]!=B[63]) & (valE[63]!=B[63])
- OF = 0 for and/xor
REQ-008 Cnd SHALL be computed for icode 2 and 7 from the CC register value held before the current instruction's update, as follows, and SHALL be 0 for all other icodes:
- ifun 0: 1
- ifun 1: (SF^OF)|ZF
- ifun 2: SF^OF
- ifun 3: ZF
- ifun 4: ~ZF
- ifun 5: ~(SF^OF)
- ifun 6: ~(SF^OF)&~ZF
- ifun >6: 0
REQ-009 Handshake: in_ready = ~halted & (~out_valid | out_ready); accept = in_valid & in_ready.
REQ-010 On accept, the output register SHALL capture icode, valE, valA, Cnd and err, and SHALL set out_valid=1 on the next edge (latency 1 cycle).
REQ-011 When out_ready=1 and there is no accept in the same cycle, out_valid SHALL clear; accept together with out_ready SHALL replace the result with no bubble.
REQ-012 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable and no CC update SHALL occur.
REQ-013 An accepted icode 0 SHALL set a sticky halted flag; after that, in_ready SHALL be 0 until reset, and the halt result itself SHALL still be delivered downstream.
REQ-014 Back-to-back OPq followed by cmov/jXX SHALL see the CC written by the preceding OPq.

Reset
REQ-015 On a clk edge with rst_n=0, the block SHALL set out_valid=0, out_icode=0, out_valE=0, out_valA=0, out_Cnd=0, out_err=0, ZF=1, SF=0, OF=0 and halted=0.
REQ-016 Reset asserted mid-transfer SHALL discard any pending result without it reaching downstream; in_ready SHALL be 0 during reset and 1 on the first cycle after.

Verification
REQ-017 Reset, then OPq add (ifun 0) with valA=0x7FFFFFFFFFFFFFFF, valB=1 -> out_valE=0x8000000000000000, ZF=0, SF=1, OF=1, out_valid one cycle after accept.
REQ-018 OPq sub with valA=5, valB=5, followed by jXX ifun 3 -> first result valE=0, ZF=1; jXX out_Cnd=1; a following jXX ifun 4 -> out_Cnd=0.
REQ-019 pushq with valB=0x100 -> valE=0xF8; popq with valB=0x100 -> valE=0x108; CC unchanged.
REQ-020 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, CC stable; release -> next instruction accepted the same cycle.
REQ-021 OPq ifun 7 -> out_err=1, valE=0, CC unchanged; halt accepted -> out_icode=0 delivered, in_ready stays 0 until rst_n=0 for one edge.
